// File: rtl/timer_defs.sv
// Shared definitions for the machine timer: register offsets,
// CTRL bit positions and the mip bit the timer interrupt drives.
package timer_defs;

    localparam logic [4:0] MTIME_LO      = 5'h00;
    localparam logic [4:0] MTIME_HI      = 5'h04;
    localparam logic [4:0] MTIMECMP_LO   = 5'h08;
    localparam logic [4:0] MTIMECMP_HI   = 5'h0C;
    localparam logic [4:0] CTRL          = 5'h10;
    localparam logic [4:0] MTIME_HI_SNAP = 5'h14;

    localparam int unsigned CTRL_COUNT_EN = 0;
    localparam int unsigned CTRL_EN_IRQ   = 1;

    localparam int unsigned MIP_MTIP = 7;

    localparam logic [1:0] CTRL_RESET = 2'b11;

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk by PRESCALE while enabled; tick is high in the
// cycle the counter wraps. Disabling clears the count.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count 0..PRESCALE-1 while enabled, restart from 0 when disabled
    always_comb begin
        tick  = en & (cnt_q == LAST);
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped mtime/mtimecmp timer with a one-cycle req/ack bus
// and a registered level interrupt feeding mip.MTIP.
module machine_timer
    import timer_defs::*;
#(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        timer_irq
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] snap_q, snap_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic        tick;
    logic        wr;
    logic        rd;
    logic [4:0]  off;
    logic        unused_addr;

    assign unused_addr = ^addr[1:0];

    timer_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (ctrl_q[CTRL_COUNT_EN]),
        .tick (tick)
    );

    // Bus decode, counter advance and compare; a write to mtime
    // overrides the tick so the written value is exact
    always_comb begin
        off        = {addr[4:2], 2'b00};
        wr         = req & we;
        rd         = req & ~we;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        snap_d     = snap_q;
        ack_d      = req;
        rdata_d    = '0;
        irq_d      = (mtime_q >= mtimecmp_q) & ctrl_q[CTRL_EN_IRQ];

        if (wr) begin
            case (off)
                MTIME_LO:    mtime_d = {mtime_q[63:32], wdata};
                MTIME_HI:    mtime_d = {wdata, mtime_q[31:0]};
                MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wdata};
                MTIMECMP_HI: mtimecmp_d = {wdata, mtimecmp_q[31:0]};
                CTRL:        ctrl_d = wdata[1:0];
                default:     ;
            endcase
        end

        if (rd) begin
            case (off)
                MTIME_LO: begin
                    rdata_d = mtime_q[31:0];
                    snap_d  = mtime_q[63:32];
                end
                MTIME_HI:      rdata_d = mtime_q[63:32];
                MTIMECMP_LO:   rdata_d = mtimecmp_q[31:0];
                MTIMECMP_HI:   rdata_d = mtimecmp_q[63:32];
                CTRL:          rdata_d = {30'd0, ctrl_q};
                MTIME_HI_SNAP: rdata_d = snap_q;
                default:       rdata_d = '0;
            endcase
        end
    end

    // Timer state, bus response and interrupt registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= CMP_RESET;
            ctrl_q     <= CTRL_RESET;
            snap_q     <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            snap_q     <= snap_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign timer_irq = irq_q;

endmodule
